// File: rtl/mod_seq_checker.sv
// Sequence checker for an up/down modulo counter: tracks the observed count,
// flags out-of-sequence samples, pulses on correct wraps and counts errors.
module mod_seq_checker #(
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mod,
  input  logic            updown,
  input  logic [2:0]      count,
  input  logic            count_vld,
  output logic            locked,
  output logic            err,
  output logic            wrap,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    UNLOCKED = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        mod_q, mod_d;
  logic [1:0]        miss_q, miss_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

  logic [2:0]        mod_m1;
  logic [2:0]        exp_val;
  logic              at_wrap;

  // Expected next value uses the direction and modulus seen in this cycle.
  always_comb begin
    mod_m1  = mod - 3'd1;
    exp_val = '0;
    at_wrap = 1'b0;
    if (updown) begin
      at_wrap = (prev_q == mod_m1);
      exp_val = at_wrap ? 3'd0 : prev_q + 3'd1;
    end else begin
      at_wrap = (prev_q == 3'd0);
      exp_val = at_wrap ? mod_m1 : prev_q - 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    miss_d    = miss_q;
    mod_d     = mod;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    err_cnt_d = err_cnt_q;

    if (mod < 3'd2) begin
      state_d = DISABLED;
      miss_d  = '0;
    end else begin
      case (state_q)
        DISABLED: state_d = UNLOCKED;
        UNLOCKED: begin
          if (count_vld && (count < mod)) begin
            prev_d  = count;
            miss_d  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          // A modulus change invalidates the tracked value; that cycle's sample is dropped.
          if (mod != mod_q) begin
            state_d = UNLOCKED;
            miss_d  = '0;
          end else if (count_vld) begin
            if (count >= mod) begin
              err_d   = 1'b1;
              miss_d  = '0;
              state_d = UNLOCKED;
            end else if (count == exp_val) begin
              prev_d = count;
              miss_d = '0;
              wrap_d = at_wrap;
            end else begin
              err_d = 1'b1;
              if (miss_q == 2'd2) begin
                miss_d  = '0;
                state_d = UNLOCKED;
              end else begin
                miss_d = miss_q + 2'd1;
                prev_d = count;
              end
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= UNLOCKED;
      prev_q    <= '0;
      mod_q     <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      mod_q     <= mod_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign err_cnt = err_cnt_q;

endmodule
